trail_ram_arbiter: RTL and testbench
====================================

TRAIL_RAM_ARBITER -- requirements
Module: trail_ram_arbiter

Interface
REQ-001 Parameter PIXELS, default 307200: number of trail RAM words (640x480).
REQ-002 Parameter CLEAR_VALUE, default 8'h00: word written during a clear sweep.
REQ-003 VGA_CLK  in  1  single clock for all logic; the trail RAM write clock.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 clear_req  in  1  level request to wipe the trail RAM; rising edge is the trigger.
REQ-006 j1_req  in  1  player 1 write request; held until granted.
REQ-007 j1_addr  in  19  player 1 write address.
REQ-008 j1_data  in  8  player 1 write word.
REQ-009 j1_gnt  out  1  player 1 request accepted this cycle.
REQ-010 j2_req, j2_addr, j2_data, j2_gnt: the same as REQ-006..009, for player 2.
REQ-011 ram_wren  out  1  trail RAM write enable.
REQ-012 ram_wraddress  out  19  trail RAM write address.
REQ-013 ram_data  out  8  trail RAM write word.
REQ-014 clear_busy  out  1  high while a clear sweep is in progress.
REQ-015 clear_done  out  1  one-cycle pulse after the last clear write.
REQ-016 drop_count  out  8  saturating count of accepted writes with address >= PIXELS.

Function
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 IDLE: a rising edge of clear_req (registered previous value) SHALL move the FSM to CLEAR on the next edge, with sweep address 0.
REQ-019 IDLE, no clear edge: if exactly one jN_req is high, jN_gnt SHALL assert combinationally in the same cycle.
REQ-020 IDLE, both requests high: the player not granted most recently SHALL be granted (round-robin); last-grant resets to player 2, so player 1 wins the first tie.
REQ-021 At most one gnt SHALL be high per cycle; a gnt SHALL never assert without its req.
REQ-022 A request SHALL be accepted in the cycle its gnt is high; the requester drops or changes req/addr/data only after sampling gnt.
REQ-023 An accepted write SHALL appear on ram_wren/ram_wraddress/ram_data exactly 1 cycle after the gnt (registered outputs).
REQ-024 An accepted write with addr >= PIXELS SHALL still be granted; ram_wren SHALL stay 0 for it and drop_count SHALL increment, saturating at 255.
REQ-025 A clear edge in the same cycle as any request SHALL win: no gnt that cycle, and the request waits.
REQ-026 CLEAR: one write of CLEAR_VALUE per cycle, to addresses 0..PIXELS-1 in order; clear_busy=1; no gnt asserted.
REQ-027 After the write to PIXELS-1 is issued, clear_done SHALL pulse for 1 cycle, clear_busy SHALL fall, and the FSM SHALL return to IDLE; total sweep is PIXELS cycles.
REQ-028 clear_req edges during CLEAR SHALL be ignored (no restart, no queuing).
REQ-029 ram_wren SHALL be 0 in every cycle that has no accepted in-range write or clear write.
REQ-030 The sweep counter SHALL be 19 bits and compare against PIXELS-1; no wrap past PIXELS-1.

Reset
REQ-031 Asserting reset_n low SHALL immediately clear the following: state=IDLE, ram_wren=0, ram_wraddress=0, ram_data=0, clear_busy=0, clear_done=0, drop_count=0, last-grant=player 2, clear_req history=0.
REQ-032 Reset during CLEAR SHALL abort the sweep; no clear_done is produced.
REQ-033 Gnts SHALL be 0 while reset_n is low.

Structure
REQ-034 Shared package trail_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, PIXELS, CLEAR_VALUE, and the IDLE/CLEAR state encoding.
REQ-035 The round-robin decision SHALL live in sub-module rr_arb2 (inputs: 2 reqs, enable; outputs: 2 one-hot gnts; owns the last-grant register).

Verification
REQ-036 j1_req only, addr 153816, data 8'h01 -> j1_gnt in cycle 0; ram_wren=1, ram_wraddress=153816, ram_data=8'h01 in cycle 1.
REQ-037 Both reqs held 4 cycles after reset -> gnts in order j1, j2, j1, j2, with 4 RAM writes each 1 cycle later.
REQ-038 clear_req rises with j2_req high -> no gnt; clear_busy for 307200 cycles writing 8'h00 to addresses 0..307199; clear_done pulse; j2 granted on the first IDLE cycle after.
REQ-039 j1 addr 307200, 300 times -> 300 gnts, no ram_wren, drop_count=255.
REQ-040 reset_n low at sweep address 1000 -> all outputs 0 at once, no clear_done; after release, j1_req is granted normally.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared constants and FSM encoding for the trail RAM write arbiter.
package trail_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIXELS   = SCREEN_W * SCREEN_H;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;
    localparam logic [DATA_W-1:0] CLEAR_VALUE = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational, last-grant is registered.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    // last_q = 1 means player 2 was granted most recently
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
            else                gnt_o = req_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        last_q <= 1'b1;
        else if (gnt_o[0]) last_q <= 1'b0;
        else if (gnt_o[1]) last_q <= 1'b1;
    end
endmodule

// File: rtl/trail_ram_arbiter.sv
// Arbitrates two player write ports onto one trail RAM write port, with a full-RAM clear sweep.
module trail_ram_arbiter #(
    parameter int          PIXELS      = trail_pkg::PIXELS,
    parameter logic [7:0]  CLEAR_VALUE = trail_pkg::CLEAR_VALUE
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic        clear_req,
    input  logic        j1_req,
    input  logic [18:0] j1_addr,
    input  logic [7:0]  j1_data,
    output logic        j1_gnt,
    input  logic        j2_req,
    input  logic [18:0] j2_addr,
    input  logic [7:0]  j2_data,
    output logic        j2_gnt,
    output logic        ram_wren,
    output logic [18:0] ram_wraddress,
    output logic [7:0]  ram_data,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [7:0]  drop_count
);
    import trail_pkg::*;

    localparam logic [18:0] LAST_ADDR = 19'(PIXELS - 1);

    state_e      state_q;
    logic        clear_prev_q;
    logic [18:0] sweep_q;
    logic        ram_wren_q;
    logic [18:0] ram_wraddress_q;
    logic [7:0]  ram_data_q;
    logic        clear_busy_q;
    logic        clear_done_q;
    logic [7:0]  drop_q;

    logic        clear_edge;
    logic        arb_en;
    logic [1:0]  gnt;
    logic [18:0] sel_addr;
    logic [7:0]  sel_data;
    logic        in_range;

    assign clear_edge = clear_req & ~clear_prev_q;
    // A clear edge pre-empts any request in the same cycle; grants are also masked in reset.
    assign arb_en     = reset_n & (state_q == ST_IDLE) & ~clear_edge;

    rr_arb2 u_arb (
        .clk   (VGA_CLK),
        .rst_n (reset_n),
        .en_i  (arb_en),
        .req_i ({j2_req, j1_req}),
        .gnt_o (gnt)
    );

    assign j1_gnt   = gnt[0];
    assign j2_gnt   = gnt[1];
    assign sel_addr = gnt[1] ? j2_addr : j1_addr;
    assign sel_data = gnt[1] ? j2_data : j1_data;
    assign in_range = 32'(sel_addr) < 32'(PIXELS);

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            clear_prev_q    <= 1'b0;
            sweep_q         <= '0;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_data_q      <= '0;
            clear_busy_q    <= 1'b0;
            clear_done_q    <= 1'b0;
            drop_q          <= '0;
        end else begin
            clear_prev_q <= clear_req;
            clear_done_q <= 1'b0;
            ram_wren_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_edge) begin
                        state_q      <= ST_CLEAR;
                        sweep_q      <= '0;
                        clear_busy_q <= 1'b1;
                    end else if (|gnt) begin
                        ram_wraddress_q <= sel_addr;
                        ram_data_q      <= sel_data;
                        ram_wren_q      <= in_range;
                        if (!in_range && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                    end
                end
                ST_CLEAR: begin
                    ram_wren_q      <= 1'b1;
                    ram_wraddress_q <= sweep_q;
                    ram_data_q      <= CLEAR_VALUE;
                    if (sweep_q == LAST_ADDR) begin
                        state_q      <= ST_IDLE;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 19'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_data      = ram_data_q;
    assign clear_busy    = clear_busy_q;
    assign clear_done    = clear_done_q;
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_trail_ram_arbiter.sv
// Directed bench for trail_ram_arbiter with a timestamp-based reference model checked every cycle.
module tb_trail_ram_arbiter;
    localparam int         P  = 1200;
    localparam logic [7:0] CV = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        j1_req = 1'b0, j2_req = 1'b0;
    logic [18:0] j1_addr = '0, j2_addr = '0;
    logic [7:0]  j1_data = '0, j2_data = '0;
    logic        j1_gnt, j2_gnt, ram_wren, clear_busy, clear_done;
    logic [18:0] ram_wraddress;
    logic [7:0]  ram_data, drop_count;

    trail_ram_arbiter #(.PIXELS(P), .CLEAR_VALUE(CV)) dut (
        .VGA_CLK(clk), .reset_n(rst_n), .clear_req(clear_req),
        .j1_req(j1_req), .j1_addr(j1_addr), .j1_data(j1_data), .j1_gnt(j1_gnt),
        .j2_req(j2_req), .j2_addr(j2_addr), .j2_data(j2_data), .j2_gnt(j2_gnt),
        .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
        .clear_busy(clear_busy), .clear_done(clear_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: clear timing is derived from the offset n of the current cycle from the
    // accepted clear edge (n=0); player writes from a one-deep pending record.
    int          m_n = -1;
    logic        m_prev = 1'b0;
    int          m_last = 2;
    logic        m_pw = 1'b0;
    logic [18:0] m_pa = '0;
    logic [7:0]  m_pd = '0;
    int          m_drop = 0;
    int          cnt_busy = 0, cnt_done = 0, cnt_wren = 0, cnt_g1 = 0, cnt_g2 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt1", 32'(j1_gnt), 0);
            chk("rst_gnt2", 32'(j2_gnt), 0);
            chk("rst_wren", 32'(ram_wren), 0);
            chk("rst_addr", 32'(ram_wraddress), 0);
            chk("rst_data", 32'(ram_data), 0);
            chk("rst_busy", 32'(clear_busy), 0);
            chk("rst_done", 32'(clear_done), 0);
            chk("rst_drop", 32'(drop_count), 0);
            m_n = -1; m_prev = 1'b0; m_last = 2; m_pw = 1'b0; m_drop = 0;
        end else begin
            logic in_clr, clr_wr, edge_acc, e1, e2, ew;
            logic [18:0] ea;
            logic [7:0]  ed;
            in_clr   = (m_n >= 1) && (m_n <= P);
            clr_wr   = (m_n >= 2) && (m_n <= P + 1);
            edge_acc = !in_clr && clear_req && !m_prev;
            e1 = 1'b0; e2 = 1'b0;
            if (!in_clr && !edge_acc) begin
                if (j1_req && j2_req) begin
                    e1 = (m_last == 2); e2 = (m_last == 1);
                end else begin
                    e1 = j1_req; e2 = j2_req;
                end
            end
            ew = clr_wr || (m_pw && (32'(m_pa) < P));
            ea = clr_wr ? 19'(m_n - 2) : m_pa;
            ed = clr_wr ? CV : m_pd;
            chk("gnt1", 32'(j1_gnt), 32'(e1));
            chk("gnt2", 32'(j2_gnt), 32'(e2));
            chk("wren", 32'(ram_wren), 32'(ew));
            chk("busy", 32'(clear_busy), 32'(in_clr));
            chk("done", 32'(clear_done), 32'(m_n == P + 1));
            chk("drop", 32'(drop_count), 32'(m_drop));
            if (ew) begin
                chk("waddr", 32'(ram_wraddress), 32'(ea));
                chk("wdata", 32'(ram_data), 32'(ed));
            end
            cnt_busy += 32'(clear_busy); cnt_done += 32'(clear_done);
            cnt_wren += 32'(ram_wren); cnt_g1 += 32'(j1_gnt); cnt_g2 += 32'(j2_gnt);
            // advance model
            m_prev = clear_req;
            m_pw   = e1 || e2;
            m_pa   = e2 ? j2_addr : j1_addr;
            m_pd   = e2 ? j2_data : j1_data;
            if (e1) m_last = 1;
            if (e2) m_last = 2;
            if (m_pw && (32'(m_pa) >= P) && m_drop < 255) m_drop++;
            if (edge_acc)     m_n = 1;
            else if (m_n >= 0) m_n++;
            if (m_n > P + 1) m_n = -1;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int s_busy, s_wren, s_done, s_g1;
        logic got;
        // reset: a pending request must not be granted
        j1_req = 1'b1; j1_addr = 19'd5;
        #1 chk("lit_rst_gnt", 32'(j1_gnt), 0);
        repeat (3) cyc();
        j1_req = 1'b0;
        rst_n = 1'b1;
        cyc();

        // single player 1 write
        j1_req = 1'b1; j1_addr = 19'd600; j1_data = 8'h01;
        #1 chk("lit_t1_gnt", 32'(j1_gnt), 1);
        cyc(); j1_req = 1'b0;
        chk("lit_t1_wren", 32'(ram_wren), 1);
        chk("lit_t1_addr", 32'(ram_wraddress), 600);
        chk("lit_t1_data", 32'(ram_data), 32'h01);

        // boundaries: last valid address, first invalid address
        j2_req = 1'b1; j2_addr = 19'(P - 1); j2_data = 8'h3C;
        cyc();
        chk("lit_hi_wren", 32'(ram_wren), 1);
        chk("lit_hi_addr", 32'(ram_wraddress), P - 1);
        j2_addr = 19'(P);
        #1 chk("lit_oor_gnt", 32'(j2_gnt), 1);
        cyc(); j2_req = 1'b0;
        chk("lit_oor_wren", 32'(ram_wren), 0);
        chk("lit_oor_drop", 32'(drop_count), 1);

        // round robin after reset: j1, j2, j1, j2
        do_reset();
        j1_req = 1'b1; j1_addr = 19'd10; j1_data = 8'h11;
        j2_req = 1'b1; j2_addr = 19'd20; j2_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lit_rr_g1", 32'(j1_gnt), 32'(i % 2 == 0));
            chk("lit_rr_g2", 32'(j2_gnt), 32'(i % 2 == 1));
            cyc();
            chk("lit_rr_wren", 32'(ram_wren), 1);
            chk("lit_rr_addr", 32'(ram_wraddress), (i % 2 == 0) ? 10 : 20);
        end
        j1_req = 1'b0; j2_req = 1'b0;
        cyc();

        // 300 out-of-range writes saturate the drop counter
        s_g1 = cnt_g1; s_wren = cnt_wren;
        j1_req = 1'b1; j1_addr = 19'(P); j1_data = 8'h99;
        repeat (300) cyc();
        j1_req = 1'b0;
        chk("lit_drop_gnts", 32'(cnt_g1 - s_g1), 300);
        cyc();
        chk("lit_drop_sat", 32'(drop_count), 255);
        chk("lit_drop_nowr", 32'(cnt_wren - s_wren), 0);

        // clear edge beats a request; a re-edge mid-sweep is ignored
        s_busy = cnt_busy; s_wren = cnt_wren; s_done = cnt_done;
        j2_req = 1'b1; j2_addr = 19'd77; j2_data = 8'h5A; clear_req = 1'b1;
        #1 chk("lit_clr_nognt", 32'(j2_gnt), 0);
        got = 1'b0;
        for (int k = 0; k < 3 * P; k++) begin
            cyc();
            if (k == 500) clear_req = 1'b0;
            if (k == 501) clear_req = 1'b1;
            #1;
            if (j2_gnt) begin
                got = 1'b1;
                chk("lit_clr_gnt_at_done", 32'(clear_done), 1);
                break;
            end
        end
        chk("lit_clr_j2_granted", 32'(got), 1);
        cyc(); j2_req = 1'b0; clear_req = 1'b0;
        chk("lit_clr_busy_cycles", 32'(cnt_busy - s_busy), P);
        chk("lit_clr_writes", 32'(cnt_wren - s_wren), P);
        chk("lit_clr_done_cnt", 32'(cnt_done - s_done), 1);
        chk("lit_clr_j2_addr", 32'(ram_wraddress), 77);
        chk("lit_clr_j2_data", 32'(ram_data), 32'h5A);

        // reset in the middle of a sweep
        cyc(); clear_req = 1'b1;
        cyc(); clear_req = 1'b0;
        s_done = cnt_done;
        got = 1'b0;
        for (int k = 0; k < 2 * P; k++) begin
            cyc();
            if (ram_wren && ram_wraddress == 19'd1000) begin got = 1'b1; break; end
        end
        chk("lit_abort_reach1000", 32'(got), 1);
        j1_req = 1'b1; j1_addr = 19'd42; j1_data = 8'h77;
        rst_n = 1'b0;
        #1;
        chk("lit_abort_wren", 32'(ram_wren), 0);
        chk("lit_abort_addr", 32'(ram_wraddress), 0);
        chk("lit_abort_busy", 32'(clear_busy), 0);
        chk("lit_abort_drop", 32'(drop_count), 0);
        chk("lit_abort_gnt", 32'(j1_gnt), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1 chk("lit_post_gnt", 32'(j1_gnt), 1);
        cyc(); j1_req = 1'b0;
        chk("lit_post_wren", 32'(ram_wren), 1);
        chk("lit_post_addr", 32'(ram_wraddress), 42);
        chk("lit_post_data", 32'(ram_data), 32'h77);
        repeat (P + 10) cyc();
        chk("lit_post_nodone", 32'(cnt_done - s_done), 0);
        chk("lit_post_idle", 32'(clear_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
